// File: rtl/digit_serial_adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder/subtractor.
package digit_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Number of digit steps per operation; guards against a zero digit so the
  // elaboration check in the top can report the real problem.
  function automatic int calc_ndig(input int width, input int digit);
    return (digit > 0) ? (width / digit) : 1;
  endfunction

  // Digit index width, clog2(NDIG), kept at least one bit for DIGIT == WIDTH.
  function automatic int calc_idx_w(input int width, input int digit);
    int n;
    n = calc_ndig(width, digit);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/digit_serial_adder_digit_adder.sv
// Combinational DIGIT-wide adder with carry in/out; one digit step of the datapath.
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder/subtractor processing DIGIT bits per clock with start/done handshake.
// Optional signed-overflow output enabled by defining DIGIT_SERIAL_ADDER_OVF_EN.
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  input  logic             SUB,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             OVF
);

  localparam int NDIG  = calc_ndig(WIDTH, DIGIT);
  localparam int IDX_W = calc_idx_w(WIDTH, DIGIT);
  localparam logic [IDX_W-1:0] LAST_K = IDX_W'(NDIG - 1);

  if (DIGIT < 1) begin : g_bad_digit
    $error("digit_serial_adder: DIGIT must be at least 1");
  end else if (((WIDTH % DIGIT) != 0) || (WIDTH < DIGIT)) begin : g_bad_width
    $error("digit_serial_adder: WIDTH must be a non-zero multiple of DIGIT");
  end

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             carry;
  logic             sub_reg;
  logic [IDX_W-1:0] k;
  logic             accept;
  logic             last_digit;
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT-1:0] d_sum;
  logic             d_cout;

  // START is only honoured outside the digit loop; FIN accepts back-to-back.
  assign accept     = START && ((state == IDLE) || (state == FIN));
  assign last_digit = (state == RUN) && (k == LAST_K);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: default assignment first so no path through the case leaves
  // state_next unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (START) state_next = RUN;
      RUN:     if (last_digit) state_next = FIN;
      FIN:     state_next = START ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    BUSY = 1'b0;
    DONE = 1'b0;
    case (state)
      RUN:     BUSY = 1'b1;
      FIN:     DONE = 1'b1;
      default: ;
    endcase
  end

  assign a_dig = a_reg[k*DIGIT +: DIGIT];
  assign b_dig = b_reg[k*DIGIT +: DIGIT];

  digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
    .a    (a_dig),
    .b    (b_dig),
    .cin  (carry),
    .sum  (d_sum),
    .cout (d_cout)
  );

  always_comb begin
    acc_next                   = acc;
    acc_next[k*DIGIT +: DIGIT] = d_sum;
  end

  // Subtraction is A + ~B + ~borrow; the carry is re-inverted into a borrow on output.
  // NOTE: every datapath register is cleared on reset so an aborted operation
  // leaves no stale operands or partial sums behind.
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      carry   <= 1'b0;
      sub_reg <= 1'b0;
      k       <= '0;
      SUM     <= '0;
      COUT    <= 1'b0;
    end else if (accept) begin
      a_reg   <= A;
      b_reg   <= SUB ? ~B : B;
      carry   <= SUB ? ~CIN : CIN;
      sub_reg <= SUB;
      k       <= '0;
      acc     <= '0;
    end else if (state == RUN) begin
      acc   <= acc_next;
      carry <= d_cout;
      k     <= last_digit ? '0 : k + IDX_W'(1);
      if (last_digit) begin
        SUM  <= acc_next;
        COUT <= sub_reg ? ~d_cout : d_cout;
      end
    end
  end

`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  logic ovf_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      ovf_reg <= 1'b0;
    end else if (last_digit && !accept) begin
      ovf_reg <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                 (acc_next[WIDTH-1] != a_reg[WIDTH-1]);
    end
  end

  assign OVF = ovf_reg;
`else
  assign OVF = 1'b0;
`endif

endmodule

// File: tb/tb_digit_serial_adder.sv
// Scoreboard bench for digit_serial_adder (WIDTH=16, DIGIT=4) with directed vectors.
module tb_digit_serial_adder;

  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int NDIG  = 4;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             RST;
  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             CIN;
  logic             SUB;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] SUM;
  logic             COUT;
  logic             OVF;

  digit_serial_adder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .A     (A),
    .B     (B),
    .CIN   (CIN),
    .SUB   (SUB),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .SUM   (SUM),
    .COUT  (COUT),
    .OVF   (OVF)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } res_t;

  typedef struct {
    res_t res;
    int   done_cyc;
  } exp_t;

  exp_t sb[$];
  res_t held;
  res_t mon_got;
  exp_t mon_e;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops an expectation on every DONE, otherwise the result must hold.
  always @(negedge CLK) begin
    if (mon_en) begin
      mon_got = {SUM, COUT, OVF};
      if (DONE) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(DONE), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("sum",        32'(SUM),  32'(mon_e.res.sum));
          check("cout",       32'(COUT), 32'(mon_e.res.cout));
          check("ovf",        32'(OVF),  32'(mon_e.res.ovf));
          check("done_cycle", 32'(cyc),  32'(mon_e.done_cyc));
          held = mon_e.res;
        end
      end else begin
        check("held_result", 32'(mon_got), 32'(held));
      end
    end
  end

  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic sub,
                       input logic [WIDTH-1:0] e_sum, input logic e_cout, input logic e_ovf);
    exp_t e;
    A     = a;
    B     = b;
    CIN   = cin;
    SUB   = sub;
    START = 1'b1;
    e.res.sum  = e_sum;
    e.res.cout = e_cout;
    e.res.ovf  = e_ovf;
    e.done_cyc = cyc + NDIG + 1;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    START = 1'b0;
    A     = 16'hDEAD;
    B     = 16'hBEEF;
    CIN   = 1'b1;
    SUB   = 1'b1;
  endtask

  // Returns at the falling edge of the DONE cycle, or flags a timeout.
  task automatic wait_done(output int busy_cnt);
    bit seen;
    seen     = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge CLK);
      if (DONE)      seen = 1'b1;
      else if (BUSY) busy_cnt++;
    end
    if (!seen) check("done_timeout", 32'(seen), 32'd1);
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sub,
                        input logic [WIDTH-1:0] e_sum, input logic e_cout, input logic e_ovf);
    int bc;
    issue(a, b, cin, sub, e_sum, e_cout, e_ovf);
    wait_done(bc);
    check("busy_cycles", 32'(bc), 32'(NDIG));
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int bc;
    RST   = 1'b1;
    START = 1'b0;
    A     = '0;
    B     = '0;
    CIN   = 1'b0;
    SUB   = 1'b0;
    held  = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_sum",  32'(SUM),  32'd0);
    check("rst_cout", 32'(COUT), 32'd0);
    check("rst_ovf",  32'(OVF),  32'd0);
    RST    = 1'b0;
    mon_en = 1'b1;
    @(posedge CLK);
    #1;

    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0);
    run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, OVF_ON);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, OVF_ON);
    run_op(16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0);
    run_op(16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b0, 1'b0);

    // START while busy must be ignored: exactly one DONE with the first result.
    issue(16'h1000, 16'h2000, 1'b0, 1'b0, 16'h3000, 1'b0, 1'b0);
    A     = 16'hAAAA;
    B     = 16'h5555;
    CIN   = 1'b0;
    SUB   = 1'b0;
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    wait_done(bc);
    repeat (10) @(posedge CLK);
    #1;
    check("ignored_start_queue", 32'(sb.size()), 32'd0);

    // Back-to-back: second START presented during the DONE cycle.
    issue(16'h0100, 16'h0023, 1'b0, 1'b0, 16'h0123, 1'b0, 1'b0);
    wait_done(bc);
    issue(16'hF000, 16'h2000, 1'b0, 1'b0, 16'h1000, 1'b1, 1'b0);
    wait_done(bc);
    check("b2b_busy_cycles", 32'(bc), 32'(NDIG));
    @(posedge CLK);
    #1;

    // Reset in the second RUN cycle aborts with no DONE.
    issue(16'h4444, 16'h1111, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    sb.delete();
    held = '0;
    check("abort_busy", 32'(BUSY), 32'd0);
    check("abort_done", 32'(DONE), 32'd0);
    check("abort_sum",  32'(SUM),  32'd0);
    check("abort_cout", 32'(COUT), 32'd0);
    check("abort_ovf",  32'(OVF),  32'd0);
    repeat (8) @(posedge CLK);
    #1;
    run_op(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);

    check("final_queue_empty", 32'(sb.size()), 32'd0);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/digit_serial_adder.md
# digit_serial_adder

Parametrised multi-cycle adder/subtractor that processes a WIDTH-bit operand pair DIGIT bits per clock. It sits beside the combinational ripple adders in the arithmetic components. It trades latency for area at wide word sizes, and adds subtract mode, a start/done handshake and held results.

## Interface
- WIDTH, 16, operand and result width; must be an integer multiple of DIGIT, ≥ DIGIT.
- DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH.
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  reset; synchronous, active-high.
- START  input  1  request; sampled only when BUSY=0.
- A  input  WIDTH  first operand; captured on accepted START.
- B  input  WIDTH  second operand; captured on accepted START.
- CIN  input  1  carry-in (add) / borrow-in (subtract); captured on accepted START.
- SUB  input  1  0: A+B+CIN; 1: A−B−CIN; captured on accepted START.
- BUSY  output  1  operation in progress.
- DONE  output  1  one-cycle pulse: result valid.
- SUM  output  WIDTH  result; held until next accepted START completes.
- COUT  output  1  carry-out (add) / borrow-out (subtract).
- OVF  output  1  two's-complement signed overflow (see Configuration).

## Operation
- NDIG = WIDTH/DIGIT digit steps per operation.
- States:
  - IDLE: after reset.
  - RUN: digit loop.
  - FIN: result valid, DONE=1 for one cycle.
- Transitions:
  - IDLE/FIN → RUN on START=1.
  - FIN → IDLE on START=0.
  - RUN → FIN after the last digit.
- Capture on accepted START:
  - a_reg=A.
  - b_reg = SUB ? ~B : B.
  - carry = SUB ? ~CIN : CIN.
  - digit index k=0.
  - sub_reg=SUB.
- RUN, each cycle:
  - Add digit k of a_reg and b_reg with carry.
  - Write DIGIT result bits into the internal accumulator at bits [k*DIGIT +: DIGIT].
  - Update carry and increment k.
- Final digit:
  - Copy the accumulator to SUM.
  - COUT = sub_reg ? ~carry : carry.
  - Compute OVF from the sign bits of a_reg, b_reg and the result.
- Arithmetic: all results are modulo 2^WIDTH; no saturation.
- START while BUSY=1 is ignored; operand inputs are don't-care while BUSY=1.
- START during the FIN cycle is accepted (back-to-back). DONE still pulses in that cycle, and the previous SUM stays on the port until the new operation finishes.
- SUM/COUT/OVF change only at the edge that enters FIN. They are never partially updated on the port.
- RST at any time, including mid-RUN: aborts the operation, goes to IDLE, clears all registers; no DONE is produced.

## Timing
- Reset values: BUSY=0, DONE=0, SUM=0, COUT=0, OVF=0, state IDLE, k=0.
- Cycle numbering: START is sampled high at edge E0.
- BUSY=1 for cycles following E0 … E(NDIG−1); digit k is processed at edge E(k+1).
- Result registers are loaded at edge E(NDIG). DONE=1 and BUSY=0 during the cycle after E(NDIG).
- Latency is START to DONE = NDIG+1 cycles (5 for 16/4).
- Throughput is one operation per NDIG+1 cycles.
- DIGIT=WIDTH is legal: one RUN cycle, latency 2.

## Configuration
- DIGIT_SERIAL_ADDER_OVF_EN:
  - Defined: OVF = (a_msb == b_msb) && (sum_msb != a_msb), using the post-inversion b_reg, registered with SUM.
  - Undefined: the overflow logic is not compiled, and OVF is tied to 0. The port list is unchanged.

## Structure
- Shared package holds:
  - State enum (IDLE, RUN, FIN).
  - Function computing NDIG.
  - Index width constant clog2(NDIG).
- One sub-module: digit_adder. It is a combinational DIGIT-wide adder with carry in/out and is instantiated once in the datapath.
- Elaboration-time checks reject WIDTH % DIGIT ≠ 0 and DIGIT < 1.

## Test plan
All scenarios use WIDTH=16, DIGIT=4.
- A=0xFFFF, B=0x0001, CIN=0, SUB=0, START 1 cycle → DONE 5 cycles later, SUM=0x0000, COUT=1, OVF=0; BUSY high for 4 cycles.
- A=0x0005, B=0x0007, CIN=0, SUB=1 → SUM=0xFFFE, COUT=1 (borrow), OVF=0. Same with A=0x0007, B=0x0005 → SUM=0x0002, COUT=0.
- A=0x7FFF, B=0x0001, ADD → SUM=0x8000, OVF=1 with macro, 0 without. A=0x8000, B=0x0001, SUB → SUM=0x7FFF, OVF=1 with macro.
- START pulsed again with new operands while BUSY=1 → ignored; first result unchanged and DONE pulses exactly once.
- Second START asserted in the DONE cycle → accepted; second DONE exactly 5 cycles after the first; SUM holds the first result until then.
- RST asserted at cycle 2 of RUN → next cycle all outputs 0 and BUSY=0; no DONE; a following START completes normally.
